// File: rtl/apb4_rcu_chdiv.sv
// apb4_rcu_chdiv: multi-channel clock-enable divider and reset sequencer behind an APB4 port.
// Optional feature macro: RCU_CH_LOCK_EN (per-channel CTRL write lock at CTRL[31]).
// Word map: 2*ch = CTRL_ch, 2*ch+1 = STAT_ch; everything else reads 0 and ignores writes.

module apb4_rcu_chdiv_ch #(
    parameter int DIV_WIDTH = 8,
    parameter int RST_CYC   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 wr_en,
    input  logic [DIV_WIDTH-1:0] wr_div,
    output logic                 en,
    output logic [DIV_WIDTH-1:0] div,
    output logic                 pend,
    output logic                 ce,
    output logic                 chrst
);
    typedef enum logic [1:0] {S_OFF, S_HOLD, S_REL} seq_t;

    seq_t                 state;
    logic [7:0]           hold;
    logic [DIV_WIDTH-1:0] div_act;
    logic [DIV_WIDTH-1:0] cnt;

    assign ce   = en && (cnt == div_act);
    assign pend = (div != div_act);

    // Divider: shadow DIV only reaches div_act at a period boundary while running,
    // so a ratio change never truncates or stretches the period in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            div     <= '0;
            div_act <= '0;
            cnt     <= '0;
        end else begin
            if (wr) begin
                en  <= wr_en;
                div <= wr_div;
            end
            if (wr && (!wr_en || !en)) begin
                // Enabling, disabling or writing while idle: ratio applies at once.
                div_act <= wr_div;
                cnt     <= '0;
            end else if (!en) begin
                cnt <= '0;
            end else if (ce) begin
                cnt     <= '0;
                div_act <= div;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Reset sequencer: hold reset for RST_CYC ce pulses after enable, drop it on disable.
    // A pulse landing on the OFF->HOLD edge (DIV=0) already counts toward the hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_OFF;
            hold  <= '0;
            chrst <= 1'b1;
        end else begin
            case (state)
                S_OFF: begin
                    if (en) begin
                        if (ce && RST_CYC == 1) begin
                            state <= S_REL;
                            chrst <= 1'b0;
                        end else begin
                            state <= S_HOLD;
                            hold  <= ce ? 8'(RST_CYC - 1) : 8'(RST_CYC);
                        end
                    end
                end
                S_HOLD: begin
                    if (!en) begin
                        state <= S_OFF;
                        chrst <= 1'b1;
                    end else if (ce) begin
                        hold <= hold - 8'd1;
                        if (hold == 8'd1) begin
                            state <= S_REL;
                            chrst <= 1'b0;
                        end
                    end
                end
                S_REL: begin
                    if (!en) begin
                        state <= S_OFF;
                        chrst <= 1'b1;
                    end
                end
                default: begin
                    state <= S_OFF;
                    chrst <= 1'b1;
                end
            endcase
        end
    end
endmodule

module apb4_rcu_chdiv #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 8,
    parameter int RST_CYC   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [7:0]        paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [NUM_CH-1:0] ce_o,
    output logic [NUM_CH-1:0] rst_o
);
    logic [4:0]                          ch_idx;
    logic                                is_stat;
    logic                                wr_acc;
    logic                                rd_acc;
    logic                                wr_ctrl;
    logic [NUM_CH-1:0]                   sel;
    logic [NUM_CH-1:0]                   lock;
    logic [NUM_CH-1:0]                   wr_ch;
    logic [NUM_CH-1:0]                   en;
    logic [NUM_CH-1:0]                   pend;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0]    div;
    logic                                unused_bits;

    assign ch_idx      = paddr_i[7:3];
    assign is_stat     = paddr_i[2];
    assign wr_acc      = psel_i & penable_i & pwrite_i;
    assign rd_acc      = psel_i & penable_i & ~pwrite_i;
    assign wr_ctrl     = wr_acc & ~is_stat;
    assign pready_o    = 1'b1;
    assign unused_bits = ^{pwdata_i, paddr_i[1:0]};

    // One-hot channel decode; unmapped words select nothing.
    always_comb begin
        sel = '0;
        for (int c = 0; c < NUM_CH; c++) sel[c] = (ch_idx == 5'(c));
    end

`ifdef RCU_CH_LOCK_EN
    // Sticky per-channel lock; the locking write itself still lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (wr_ctrl && sel[c] && !lock[c] && pwdata_i[31]) lock[c] <= 1'b1;
        end
    end
    assign pslverr_o = wr_ctrl & (|(sel & lock));
`else
    assign lock      = '0;
    assign pslverr_o = 1'b0;
`endif

    assign wr_ch = {NUM_CH{wr_ctrl}} & sel & ~lock;

    // Combinational read mux, zero outside a read access phase.
    always_comb begin
        logic [31:0] v;
        prdata_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            v                 = '0;
            v[0]              = en[c];
            v[8 +: DIV_WIDTH] = div[c];
            v[31]             = lock[c];
            if (rd_acc && sel[c])
                prdata_o = is_stat ? {29'b0, pend[c], ~rst_o[c], en[c]} : v;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        apb4_rcu_chdiv_ch #(
            .DIV_WIDTH(DIV_WIDTH),
            .RST_CYC  (RST_CYC)
        ) u_ch (
            .clk   (clk_i),
            .reset (rst_i),
            .wr    (wr_ch[g]),
            .wr_en (pwdata_i[0]),
            .wr_div(pwdata_i[8 +: DIV_WIDTH]),
            .en    (en[g]),
            .div   (div[g]),
            .pend  (pend[g]),
            .ce    (ce_o[g]),
            .chrst (rst_o[g])
        );
    end
endmodule

// File: tb/tb_apb4_rcu_chdiv.sv
// tb_apb4_rcu_chdiv: directed scenarios plus a randomized run against a timeline model.
// The model tracks each channel by the absolute cycle of its next pulse and the number
// of pulses seen since enable. Honours RCU_CH_LOCK_EN when defined.

module tb_apb4_rcu_chdiv;
    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int RC  = 4;
`ifdef RCU_CH_LOCK_EN
    localparam bit LOCKED = 1'b1;
`else
    localparam bit LOCKED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic            psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]      paddr = '0;
    logic [31:0]     pwdata = '0;
    logic [31:0]     prdata;
    logic            pready, pslverr;
    logic [NCH-1:0]  ce_o, rst_o;

    int checks = 0;
    int errors = 0;

    apb4_rcu_chdiv #(.NUM_CH(NCH), .DIV_WIDTH(DW), .RST_CYC(RC)) dut (
        .clk_i(clk), .rst_i(rst_i), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
        .pslverr_o(pslverr), .ce_o(ce_o), .rst_o(rst_o));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int cyc = 0;
    int m_en[NCH], m_sh[NCH], m_act[NCH], m_next[NCH], m_pul[NCH], m_rel[NCH], m_lock[NCH];

    function automatic logic [NCH-1:0] exp_ce();
        for (int c = 0; c < NCH; c++) exp_ce[c] = (m_en[c] != 0) && (cyc == m_next[c]);
    endfunction

    function automatic logic [NCH-1:0] exp_rst();
        for (int c = 0; c < NCH; c++) exp_rst[c] = (m_rel[c] == 0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        int w = int'(a[7:2]);
        int c = w / 2;
        if (c >= NCH) return 32'h0;
        if (w % 2 == 1) return 32'((m_sh[c] != m_act[c]) << 2 | m_rel[c] << 1 | m_en[c]);
        return 32'(m_lock[c] << 31 | m_sh[c] << 8 | m_en[c]);
    endfunction

    function automatic logic exp_err();
        int w = int'(paddr[7:2]);
        if (!(psel && penable && pwrite) || (w % 2 == 1) || (w / 2 >= NCH)) return 1'b0;
        return m_lock[w / 2] != 0;
    endfunction

    task automatic model_step();
        logic [NCH-1:0] ce;
        int w, nd, ne;
        ce = exp_ce();
        w  = int'(paddr[7:2]);
        for (int c = 0; c < NCH; c++) begin
            if (rst_i) begin
                m_en[c] = 0; m_sh[c] = 0; m_act[c] = 0; m_next[c] = 0;
                m_pul[c] = 0; m_rel[c] = 0; m_lock[c] = 0;
                continue;
            end
            if (m_en[c] == 0) begin
                m_pul[c] = 0; m_rel[c] = 0;
            end else if (ce[c]) begin
                m_pul[c]++;
                if (m_pul[c] >= RC) m_rel[c] = 1;
            end
            if (psel && penable && pwrite && w == 2 * c && m_lock[c] == 0) begin
                ne = int'(pwdata[0]);
                nd = int'(pwdata[8 +: DW]);
                if (ne == 0 || m_en[c] == 0) begin
                    m_act[c] = nd; m_next[c] = cyc + 1 + nd;
                end else if (ce[c]) begin
                    m_act[c] = m_sh[c]; m_next[c] = cyc + 1 + m_sh[c];
                end
                m_sh[c] = nd;
                m_en[c] = ne;
                if (LOCKED && pwdata[31]) m_lock[c] = 1;
            end else if (m_en[c] != 0 && ce[c]) begin
                m_act[c] = m_sh[c]; m_next[c] = cyc + 1 + m_sh[c];
            end
        end
        cyc++;
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        tick();
        penable = 1'b1;
        #1 err = pslverr;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        tick();
        penable = 1'b1;
        #1 d = prdata;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    // Ticks until ce_o[c] is high; n = ticks taken, -1 if the budget ran out.
    task automatic wait_ce(input int c, input int maxn, output int n);
        n = 0;
        while (ce_o[c] !== 1'b1 && n < maxn) begin tick(); n++; end
        if (ce_o[c] !== 1'b1) n = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
        checks++; if (rst_o !== 4'hF) begin errors++; $display("FAIL reset_rst got %h want f", rst_o); end
        checks++; if (ce_o !== 4'h0) begin errors++; $display("FAIL reset_ce got %h want 0", ce_o); end
        checks++; if (prdata !== 32'h0 || pslverr !== 1'b0) begin errors++; $display("FAIL reset_idle prdata %h pslverr %b want 0/0", prdata, pslverr); end
        apb_read(8'h00, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl0 got %h want 0", d); end
        apb_read(8'h04, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_stat0 got %h want 0", d); end
    endtask

    task automatic test_enable();
        logic err; logic [31:0] d; int n;
        apb_write(8'h00, 32'h301, err);
        wait_ce(0, 20, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL en_first_ce got %0d want 3", n); end
        for (int k = 1; k <= 3; k++) begin
            checks++; if (rst_o[0] !== 1'b1) begin errors++; $display("FAIL en_hold%0d got %b want 1", k, rst_o[0]); end
            tick();
            checks++; if (ce_o[0] !== 1'b0) begin errors++; $display("FAIL en_pulse_width got %b want 0", ce_o[0]); end
            wait_ce(0, 20, n);
            checks++; if (n !== 3) begin errors++; $display("FAIL en_period%0d got %0d want 3", k, n); end
        end
        checks++; if (rst_o[0] !== 1'b1) begin errors++; $display("FAIL en_hold4 got %b want 1", rst_o[0]); end
        tick();
        checks++; if (rst_o[0] !== 1'b0) begin errors++; $display("FAIL en_release got %b want 0", rst_o[0]); end
        apb_read(8'h04, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL en_stat got %h want 3", d); end
    endtask

    task automatic test_ratio();
        logic err; logic [31:0] d; int n;
        wait_ce(0, 20, n);
        checks++; if (n < 0) begin errors++; $display("FAIL ratio_sync got %0d want >=0", n); end
        apb_write(8'h00, 32'h101, err);
        apb_read(8'h04, d);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL ratio_pend got %h want 7", d); end
        checks++; if (ce_o[0] !== 1'b1) begin errors++; $display("FAIL ratio_old_period got %b want 1", ce_o[0]); end
        tick();
        wait_ce(0, 20, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL ratio_new_period got %0d want 1", n); end
        apb_read(8'h04, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL ratio_pend_clr got %h want 3", d); end
        wait_ce(0, 20, n); tick(); wait_ce(0, 20, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL ratio_new_period2 got %0d want 1", n); end
    endtask

    task automatic test_disable();
        logic err; logic [31:0] d; int n, cnt;
        apb_write(8'h00, 32'h0, err);
        checks++; if (ce_o[0] !== 1'b0 || rst_o[0] !== 1'b0) begin errors++; $display("FAIL dis_t1 ce %b rst %b want 0/0", ce_o[0], rst_o[0]); end
        tick();
        checks++; if (rst_o[0] !== 1'b1) begin errors++; $display("FAIL dis_t2_rst got %b want 1", rst_o[0]); end
        cnt = 0;
        for (int i = 0; i < 8; i++) begin tick(); cnt += int'(ce_o[0]); end
        checks++; if (cnt !== 0) begin errors++; $display("FAIL dis_quiet got %0d pulses want 0", cnt); end
        apb_read(8'h04, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL dis_stat got %h want 0", d); end
        apb_write(8'h00, 32'h301, err);
        for (int k = 1; k <= 4; k++) begin
            wait_ce(0, 20, n);
            checks++; if (n !== 3 || rst_o[0] !== 1'b1) begin errors++; $display("FAIL reen_hold%0d gap %0d rst %b want 3/1", k, n, rst_o[0]); end
            tick();
        end
        checks++; if (rst_o[0] !== 1'b0) begin errors++; $display("FAIL reen_release got %b want 0", rst_o[0]); end
    endtask

    task automatic test_independence();
        logic err; logic [31:0] d; logic [NCH-1:0] e;
        rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
        apb_write(8'h08, 32'h001, err);
        apb_write(8'h10, 32'h701, err);
        for (int i = 0; i < 16; i++) begin
            e = 4'b0010;
            e[2] = (i % 8 == 7);
            checks++; if (ce_o !== e) begin errors++; $display("FAIL indep_ce%0d got %b want %b", i, ce_o, e); end
            tick();
        end
        checks++; if (rst_o !== 4'b1101) begin errors++; $display("FAIL indep_rst got %b want 1101", rst_o); end
        apb_read(8'hFC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL indep_word3f got %h want 0", d); end
        apb_read(8'h24, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL indep_word9 got %h want 0", d); end
    endtask

    task automatic test_lock();
        logic err; logic [31:0] d;
        apb_write(8'h08, 32'h8000_0001, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lock_first_err got %b want 0", err); end
        apb_write(8'h08, 32'h0, err);
        checks++; if (err !== LOCKED) begin errors++; $display("FAIL lock_second_err got %b want %b", err, LOCKED); end
        apb_read(8'h08, d);
        checks++; if (d !== (LOCKED ? 32'h8000_0001 : 32'h0)) begin errors++; $display("FAIL lock_ctrl1 got %h", d); end
        apb_write(8'hF0, 32'hFFFF_FFFF, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lock_unmapped_err got %b want 0", err); end
    endtask

    task automatic test_random();
        logic busy; logic [5:0] w6; logic [31:0] d;
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            checks++; if (ce_o !== exp_ce()) begin errors++; $display("FAIL rnd_ce cyc %0d got %b want %b", i, ce_o, exp_ce()); end
            checks++; if (rst_o !== exp_rst()) begin errors++; $display("FAIL rnd_rst cyc %0d got %b want %b", i, rst_o, exp_rst()); end
            if (busy) begin
                penable = 1'b1;
                #1;
                checks++; if (pslverr !== exp_err()) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", i, pslverr, exp_err()); end
                checks++; if (prdata !== (pwrite ? 32'h0 : exp_read(paddr))) begin errors++; $display("FAIL rnd_rd cyc %0d addr %h got %h", i, paddr, prdata); end
            end else if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 7) == 0) w6 = 6'($urandom_range(0, 63));
                else w6 = {3'b0, 2'($urandom_range(0, NCH - 1)), 1'($urandom_range(0, 5) == 0)};
                d        = $urandom;
                d[0]     = ($urandom_range(0, 3) != 0);
                d[15:8]  = 8'($urandom_range(0, 5));
                d[31]    = ($urandom_range(0, 63) == 0);
                paddr    = {w6, 2'b00};
                pwdata   = d;
                pwrite   = ($urandom_range(0, 3) != 0);
                psel     = 1'b1;
                penable  = 1'b0;
            end else begin
                psel = 1'b0;
            end
            rst_i = (i == 1000);
            tick();
            rst_i = 1'b0;
            if (busy) begin psel = 1'b0; penable = 1'b0; busy = 1'b0; end
            else if (psel) busy = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_ratio();
        test_disable();
        test_independence();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
